// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetches one word at a time from the instruction SRAM,
// holds it until the pipeline accepts it, and queues redirects behind the delay slot.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic [32:0] br_bus,
  output logic [32:0] if_to_id_bus,
  output logic [31:0] inst_out,
  output logic        stallreq,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] buf_q, buf_d;
  logic [32:0] bus_q, bus_d;
  logic [31:0] inst_q, inst_d;

  logic        br_e_s;
  logic [31:0] br_addr_s;
  logic [31:0] next_pc_s;
  logic        deliver_s;
  logic        bubble_s;
  logic        unused_s;

  assign br_e_s    = br_bus[32];
  assign br_addr_s = {br_bus[31:2], 2'b00};
  assign unused_s  = ^{stall[5:3], br_bus[1:0]};

  // A redirect arriving on the advancing edge is newer than any pending target.
  assign next_pc_s = br_e_s    ? br_addr_s :
                     br_pend_q ? br_tgt_q  : (pc_q + 32'd4);

  // Next-state, buffer, delivery and pending-branch logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    br_tgt_d  = br_tgt_q;
    br_pend_d = br_pend_q;
    buf_d     = buf_q;
    bus_d     = bus_q;
    inst_d    = inst_q;
    deliver_s = 1'b0;
    bubble_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        pc_d    = RESET_PC;
      end
      S_REQ: begin
        if (inst_sram_addr_ok) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (inst_sram_data_ok) begin
          buf_d   = inst_sram_rdata;
          state_d = S_HOLD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if ((stall[0] == NO_STOP) && (stall[1] == NO_STOP)) begin
          deliver_s = 1'b1;
        end else if ((stall[1] == STOP) && (stall[2] == NO_STOP)) begin
          bubble_s = 1'b1;
        end else begin
          deliver_s = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (deliver_s) begin
      bus_d     = {1'b1, pc_q};
      inst_d    = buf_q;
      pc_d      = next_pc_s;
      br_pend_d = 1'b0;
      state_d   = S_REQ;
    end else if (bubble_s) begin
      bus_d  = 33'd0;
      inst_d = 32'd0;
    end else begin
      bus_d  = bus_q;
      inst_d = inst_q;
    end

    // pc holds on every non-delivery edge, so a redirect here must be remembered.
    if (!deliver_s && br_e_s) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_addr_s;
    end else begin
      br_tgt_d  = br_tgt_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      br_tgt_q  <= 32'd0;
      br_pend_q <= 1'b0;
      buf_q     <= 32'd0;
      bus_q     <= 33'd0;
      inst_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      br_tgt_q  <= br_tgt_d;
      br_pend_q <= br_pend_d;
      buf_q     <= buf_d;
      bus_q     <= bus_d;
      inst_q    <= inst_d;
    end
  end

  assign if_to_id_bus   = bus_q;
  assign inst_out       = inst_q;
  assign inst_sram_req  = (state_q == S_REQ);
  assign inst_sram_addr = pc_q;
  assign stallreq       = (state_q == S_REQ) | (state_q == S_WAIT);

endmodule
